// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader and its RAM.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction RAM: synchronous write port, asynchronous read port.
module imem_ram
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Fills the instruction RAM from a little-endian byte stream, zero-fills the
// remainder, and holds the CPU in reset until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              load_req,
    input  logic [31:0]       addr,
    output logic [WORD_W-1:0] instr,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              overflow,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W:0] DEPTH_W  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] LAST_IDX = DEPTH_W - 1'b1;

    state_t              state, state_nx;
    logic [ADDR_W:0]     wptr;
    logic [1:0]          bcnt;
    logic [23:0]         shreg;
    logic                accept, full, word_cmp, we;
    logic [WORD_W-1:0]   word_nx, wdata;
    logic                unused_addr;

    // Bytes below idx come from the shift register, idx gets the new byte,
    // bytes above idx are zero so a short final word is zero-padded.
    function automatic logic [WORD_W-1:0] pack_byte(input logic [23:0] sr,
                                                    input logic [1:0]  idx,
                                                    input logic [7:0]  b);
        logic [WORD_W-1:0] w;
        logic [WORD_W-1:0] srx;
        w   = '0;
        srx = {8'h00, sr};
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (i < int'(idx)) begin
                w[8*i +: 8] = srx[8*i +: 8];
            end else if (i == int'(idx)) begin
                w[8*i +: 8] = b;
            end
        end
        return w;
    endfunction

    assign full     = (wptr == DEPTH_W);
    assign accept   = in_valid & in_ready;
    assign word_nx  = pack_byte(shreg, bcnt, in_data);
    assign word_cmp = accept & ~full & ((bcnt == 2'd3) | in_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD: begin
                if (accept && in_last) begin
                    state_nx = (!full && ((wptr + 1'b1) < DEPTH_W)) ? FILL : DONE;
                end
            end
            FILL: begin
                if (wptr == LAST_IDX) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (load_req) begin
                    state_nx = LOAD;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        cpu_hold  = 1'b1;
        load_done = 1'b0;
        we        = 1'b0;
        wdata     = word_nx;
        case (state)
            LOAD: begin
                in_ready = ~reset;
                we       = word_cmp;
            end
            FILL: begin
                we    = ~reset;
                wdata = '0;
            end
            DONE: begin
                cpu_hold  = 1'b0;
                load_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr         <= '0;
            bcnt         <= '0;
            words_loaded <= '0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (full) begin
                            overflow <= 1'b1;
                        end else if (word_cmp) begin
                            wptr         <= wptr + 1'b1;
                            words_loaded <= words_loaded + 1'b1;
                            bcnt         <= '0;
                        end else begin
                            bcnt <= bcnt + 2'd1;
                        end
                    end
                end
                FILL: wptr <= wptr + 1'b1;
                DONE: begin
                    if (load_req) begin
                        wptr         <= '0;
                        bcnt         <= '0;
                        words_loaded <= '0;
                        overflow     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath register: no reset needed, bytes are only consumed once valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= word_nx[23:0];
        end
    end

    assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

    imem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr[ADDR_W-1:0]),
        .wdata (wdata),
        .raddr (addr[ADDR_W+1:2]),
        .rdata (instr)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a scoreboard of expected RAM words.
module tb_imem_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              load_req;
    logic [31:0]       addr;
    logic [31:0]       instr;
    logic              cpu_hold;
    logic              load_done;
    logic              overflow;
    logic [ADDR_W:0]   words_loaded;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  bytes [$];
    logic [31:0] sb [$];
    logic [31:0] exp_img [DEPTH];
    int          exp_wl;
    logic        exp_ovf;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .load_req     (load_req),
        .addr         (addr),
        .instr        (instr),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .overflow     (overflow),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Independent model: little-endian packing, zero fill, DEPTH-word cap.
    task automatic build_expect();
        for (int i = 0; i < DEPTH; i++) exp_img[i] = '0;
        for (int i = 0; i < bytes.size() && i < 4*DEPTH; i++)
            exp_img[i/4][8*(i%4) +: 8] = bytes[i];
        exp_wl  = (bytes.size() + 3) / 4;
        if (exp_wl > DEPTH) exp_wl = DEPTH;
        exp_ovf = (bytes.size() > 4*DEPTH);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_stream(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            send_byte(bytes[i], (i == bytes.size() - 1));
            if (gap && i != bytes.size() - 1) begin
                @(negedge clk);
                check("ready_in_gap", {31'd0, in_ready}, 32'd1);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!load_done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!load_done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_image(input string tag);
        for (int i = 0; i < DEPTH; i++) sb.push_back(exp_img[i]);
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] e;
            e    = sb.pop_front();
            addr = {$urandom_range(0, 255), 16'h0, 2'b00, 6'(i), 2'(i)};
            #1;
            check(tag, instr, e);
        end
        check({tag, "_words"}, 32'(words_loaded), 32'(exp_wl));
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    endtask

    task automatic reload();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        check("reload_hold", {31'd0, cpu_hold}, 32'd1);
        check("reload_done", {31'd0, load_done}, 32'd0);
        check("reload_words", 32'(words_loaded), 32'd0);
        check("reload_ovf", {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        load_req = 1'b0;
        addr     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Two-word program, then 62 cycles of zero fill
        bytes = '{8'h00, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'h81, 8'hE2};
        build_expect();
        send_stream(bytes.size(), 1'b0);
        wait_done(n);
        check("s1_fill_cycles", 32'(n), 32'd62);
        check("s1_hold", {31'd0, cpu_hold}, 32'd0);
        check_image("s1_img");

        // Partial final word is zero-padded
        reload();
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        build_expect();
        send_stream(bytes.size(), 1'b0);
        wait_done(n);
        check("s2_fill_cycles", 32'(n), 32'd62);
        check_image("s2_img");

        // Stream 1 again with idle gaps between bytes
        reload();
        bytes = '{8'h00, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'h81, 8'hE2};
        build_expect();
        send_stream(bytes.size(), 1'b1);
        wait_done(n);
        check("s4_fill_cycles", 32'(n), 32'd62);
        check_image("s4_img");

        // Overrun: 260 bytes, last four discarded, straight to DONE
        reload();
        bytes.delete();
        for (int i = 0; i < 260; i++) bytes.push_back(8'((i * 7 + 3) & 8'hFF));
        build_expect();
        send_stream(bytes.size(), 1'b0);
        check("s3_done_next", {31'd0, load_done}, 32'd1);
        wait_done(n);
        check("s3_fill_cycles", 32'(n), 32'd0);
        check_image("s3_img");

        // Single word reload: hold stays high through 63 fill cycles
        reload();
        bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        build_expect();
        send_stream(bytes.size(), 1'b0);
        check("s5_hold_fill", {31'd0, cpu_hold}, 32'd1);
        wait_done(n);
        check("s5_fill_cycles", 32'(n), 32'd63);
        check("s5_hold", {31'd0, cpu_hold}, 32'd0);
        check_image("s5_img");

        // Reset after two words of a four-word stream, then restart
        reload();
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                  8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};
        build_expect();
        send_stream(8, 1'b0);
        check("s6_words_mid", 32'(words_loaded), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        check("s6_rst_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("s6_hold", {31'd0, cpu_hold}, 32'd1);
        check("s6_words", 32'(words_loaded), 32'd0);
        send_stream(bytes.size(), 1'b0);
        wait_done(n);
        check("s6_fill_cycles", 32'(n), 32'd60);
        check_image("s6_img");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
